// File: rtl/bcd_timer_pkg.sv
// Shared constants and helpers for the BCD down-timer: state encoding,
// the largest legal BCD digit and a digit clamp.
package bcd_timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Non-decimal nibbles (A-F) are forced to 9 so the count stays valid BCD.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD digit of the down-counter: loads a clamped preset, decrements on
// borrow-in and passes the borrow upward when it wraps from 0 to 9.
module bcd_digit_dn
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bout
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= bcd_clamp(ld_val);
        end else if (bin) begin
            q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        end
    end

    assign bout = bin & (q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter/timer with IDLE/RUN/DONE control,
// a registered wrap (b) pulse and a registered expiry (done) pulse.
module bcd_down_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b0
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                stop,
    input  logic                en,
    output logic [4*DIGITS-1:0] out,
    output logic                b,
    output logic                done,
    output logic                zero,
    output logic                busy
);

    localparam int W = 4 * DIGITS;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          done_nxt;
    logic          b_nxt;
    logic          run_en;
    logic [DIGITS:0] borrow;

    // Digit chain: digit 0 takes the run enable, each higher digit the
    // borrow of the one below. Borrow out of the top digit means a full wrap.
    assign borrow[0] = run_en;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit_dn u_digit (
            .clk    (clk),
            .clr    (clr),
            .ld     (load),
            .ld_val (load_val[4*gi +: 4]),
            .bin    (borrow[gi]),
            .q      (out[4*gi +: 4]),
            .bout   (borrow[gi+1])
        );
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            b     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            b     <= b_nxt;
        end
    end

    // Priority per edge: load > stop > start > en.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (load) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (zero && !WRAP) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nxt = ST_IDLE;
                    end else if (en && !WRAP && (out == W'(1))) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end
                ST_DONE: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
        b_nxt = WRAP && borrow[DIGITS] && !load;
    end

    // Without WRAP a zero count never decrements, so it cannot roll to nines.
    always_comb begin
        zero   = (out == '0);
        busy   = (state == ST_RUN);
        run_en = busy && en && !stop && !load && (WRAP || !zero);
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: one WRAP=0 and one WRAP=1 instance share the
// stimulus and are checked every cycle against a decimal-integer model.
module tb_bcd_down_timer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic       clk = 1'b0;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       stop;
    logic       en;

    logic [7:0] out0, out1;
    logic       b0, b1, done0, done1, zero0, zero1, busy0, busy1;

    int n_checks = 0;
    int n_err    = 0;

    int m_cnt[2];
    int m_st[2];
    bit m_b[2];
    bit m_done[2];
    logic [7:0] exp_q[$];

    bcd_down_timer #(.DIGITS(2), .WRAP(1'b0)) u_dut0 (
        .clk(clk), .clr(clr), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .en(en),
        .out(out0), .b(b0), .done(done0), .zero(zero0), .busy(busy0)
    );

    bcd_down_timer #(.DIGITS(2), .WRAP(1'b1)) u_dut1 (
        .clk(clk), .clr(clr), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .en(en),
        .out(out1), .b(b1), .done(done1), .zero(zero1), .busy(busy1)
    );

    // clock / reset
    always #10 clk = ~clk;

    function automatic int bcd_to_int(input logic [7:0] v);
        int d0, d1;
        d0 = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        d1 = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        return d1 * 10 + d0;
    endfunction

    function automatic logic [7:0] int_to_bcd(input int n);
        logic [3:0] hi, lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_cnt[w]  = 0;
            m_st[w]   = M_IDLE;
            m_b[w]    = 1'b0;
            m_done[w] = 1'b0;
        end
    endtask

    // Reference model: w==1 is the wrapping instance.
    task automatic model_edge();
        for (int w = 0; w < 2; w++) begin
            m_b[w]    = 1'b0;
            m_done[w] = 1'b0;
            if (load) begin
                m_cnt[w] = bcd_to_int(load_val);
                m_st[w]  = M_IDLE;
            end else if (m_st[w] == M_IDLE) begin
                if (start) begin
                    if (m_cnt[w] == 0 && w == 0) begin
                        m_st[w]   = M_DONE;
                        m_done[w] = 1'b1;
                    end else begin
                        m_st[w] = M_RUN;
                    end
                end
            end else if (m_st[w] == M_RUN) begin
                if (stop) begin
                    m_st[w] = M_IDLE;
                end else if (en) begin
                    if (m_cnt[w] == 0) begin
                        m_cnt[w] = 99;
                        m_b[w]   = 1'b1;
                    end else begin
                        m_cnt[w] = m_cnt[w] - 1;
                        if (m_cnt[w] == 0 && w == 0) begin
                            m_st[w]   = M_DONE;
                            m_done[w] = 1'b1;
                        end
                    end
                end
            end
            exp_q.push_back(int_to_bcd(m_cnt[w]));
        end
    endtask

    task automatic compare_all();
        check("out0",  out0,  exp_q.pop_front());
        check("b0",    b0,    m_b[0]);
        check("done0", done0, m_done[0]);
        check("zero0", zero0, m_cnt[0] == 0);
        check("busy0", busy0, m_st[0] == M_RUN);
        check("out1",  out1,  exp_q.pop_front());
        check("b1",    b1,    m_b[1]);
        check("done1", done1, m_done[1]);
        check("zero1", zero1, m_cnt[1] == 0);
        check("busy1", busy1, m_st[1] == M_RUN);
    endtask

    // driver: apply inputs, advance one edge, compare on the falling edge
    task automatic step(input logic l, input logic [7:0] lv, input logic s,
                        input logic sp, input logic e);
        load = l; load_val = lv; start = s; stop = sp; en = e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        clr = 1'b0; load = 1'b1; load_val = 8'h42; start = 1'b0; stop = 1'b0; en = 1'b0;

        // reset with load held active
        #5;
        check("rst_out0", out0, 8'h00);
        check("rst_zero0", zero0, 1'b1);
        check("rst_busy0", busy0, 1'b0);
        check("rst_done0", done0, 1'b0);
        check("rst_b1", b1, 1'b0);
        #10;
        check("rst_hold_out0", out0, 8'h00);
        check("rst_hold_out1", out1, 8'h00);
        #10;
        clr = 1'b1; load = 1'b0;
        step(0, 8'h00, 0, 0, 0);

        // borrow across digits, pause, stop
        step(1, 8'h12, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        repeat (4) step(0, 8'h00, 0, 0, 1);
        check("borrow_out0", out0, 8'h08);
        repeat (3) step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 1, 1);
        check("stop_busy0", busy0, 1'b0);
        check("stop_out0", out0, 8'h08);

        // expiry (WRAP=0) then DONE ignores start/en
        step(1, 8'h03, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        repeat (3) step(0, 8'h00, 0, 0, 1);
        check("expire_done0", done0, 1'b1);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        check("done_hold_out0", out0, 8'h00);
        step(1, 8'h05, 0, 0, 0);
        check("reload_out0", out0, 8'h05);

        // wrap-around (WRAP=1)
        step(1, 8'h01, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        check("wrap_out1", out1, 8'h99);
        check("wrap_b1", b1, 1'b1);
        step(0, 8'h00, 0, 0, 1);
        check("wrap_next_out1", out1, 8'h98);

        // clamp and load priority over start/en in RUN
        step(1, 8'hA7, 0, 0, 0);
        check("clamp_out0", out0, 8'h97);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h55, 1, 0, 1);
        check("prio_out0", out0, 8'h55);
        check("prio_busy0", busy0, 1'b0);

        // asynchronous reset between edges while running
        step(1, 8'h37, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        #3;
        clr = 1'b0;
        #1;
        check("areset_out0", out0, 8'h00);
        check("areset_busy0", busy0, 1'b0);
        check("areset_out1", out1, 8'h00);
        check("areset_busy1", busy1, 1'b0);
        model_reset();
        @(negedge clk);
        clr = 1'b1;
        step(0, 8'h00, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 8, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 75);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
